// File: rtl/instruction_memory_loader.sv
// instruction_memory_loader
// Packs one MIPS instruction, given as R-format fields, into a 32-bit word
// and writes it big-endian into the byte-wide instruction store, one byte
// per clock. Byte k of the word (k=0 is the most-significant byte) lands at
// write_address+k, matching the byte order the fetch path reads back.
//
// Optional build macro: INSTMEM_LOADER_VERIFY_EN
//   When defined, a 4-cycle VERIFY pass reads the four bytes back through
//   mem_rdata before done is raised. A read-back mismatch ends the
//   transaction with err instead of done.
module instruction_memory_loader #(
  parameter int DEPTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       op,
  input  logic [4:0]       rs,
  input  logic [4:0]       rt,
  input  logic [4:0]       rd,
  input  logic [4:0]       shamt,
  input  logic [5:0]       func,
  input  logic [31:0]      write_address,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [7:0]       mem_wdata,
  input  logic [7:0]       mem_rdata,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] loaded_count
);

  // Highest base address whose four bytes still fit inside the store.
  localparam logic [31:0] MAX_BASE = 32'(DEPTH - 4);
  localparam logic [CNT_W-1:0] COUNT_MAX = {CNT_W{1'b1}};

`ifdef INSTMEM_LOADER_VERIFY_EN
  typedef enum logic [2:0] {IDLE, WRITE, VERIFY, DONE, ERR} state_t;
`else
  typedef enum logic [1:0] {IDLE, WRITE, DONE, ERR} state_t;
`endif

  state_t      state_reg;
  logic [31:0] word_reg;
  logic [31:0] base_reg;
  logic [1:0]  idx_reg;
  logic [31:0] packed_word;
  logic [1:0]  idx_next;

  assign packed_word = {op, rs, rt, rd, shamt, func};
  assign idx_next    = idx_reg + 2'd1;

  // Big-endian byte selection: index 0 is bits 31:24.
  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] k);
    logic [7:0] b;
    case (k)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

`ifdef INSTMEM_LOADER_VERIFY_EN
  logic verify_bad_reg;
  logic rdata_bad;

  // Read-back of the byte currently addressed differs from what was written.
  assign rdata_bad = (mem_rdata != byte_sel(word_reg, idx_reg));
`else
  // Read data only matters for the read-back pass.
  logic unused_rdata;
  assign unused_rdata = ^mem_rdata;
`endif

  // Loader FSM: all outputs are registered and updated alongside the state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      word_reg     <= '0;
      base_reg     <= '0;
      idx_reg      <= '0;
      in_ready     <= 1'b1;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      done         <= 1'b0;
      err          <= 1'b0;
      loaded_count <= '0;
`ifdef INSTMEM_LOADER_VERIFY_EN
      verify_bad_reg <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            word_reg <= packed_word;
            base_reg <= write_address;
            idx_reg  <= 2'd0;
            in_ready <= 1'b0;
            if (write_address > MAX_BASE) begin
              // Word would run past the end of the store: reject, no writes.
              state_reg <= ERR;
              err       <= 1'b1;
            end else begin
              state_reg <= WRITE;
              mem_we    <= 1'b1;
              mem_addr  <= write_address;
              mem_wdata <= packed_word[31:24];
            end
          end
        end

        WRITE: begin
          if (idx_reg == 2'd3) begin
            mem_we <= 1'b0;
`ifdef INSTMEM_LOADER_VERIFY_EN
            state_reg      <= VERIFY;
            idx_reg        <= 2'd0;
            mem_addr       <= base_reg;
            verify_bad_reg <= 1'b0;
`else
            state_reg <= DONE;
            done      <= 1'b1;
            if (loaded_count != COUNT_MAX) begin
              loaded_count <= loaded_count + CNT_W'(1);
            end
`endif
          end else begin
            idx_reg   <= idx_next;
            mem_addr  <= base_reg + {30'd0, idx_next};
            mem_wdata <= byte_sel(word_reg, idx_next);
          end
        end

`ifdef INSTMEM_LOADER_VERIFY_EN
        VERIFY: begin
          // All four bytes are always read so the outcome has fixed latency.
          if (idx_reg == 2'd3) begin
            if (verify_bad_reg || rdata_bad) begin
              state_reg <= ERR;
              err       <= 1'b1;
            end else begin
              state_reg <= DONE;
              done      <= 1'b1;
              if (loaded_count != COUNT_MAX) begin
                loaded_count <= loaded_count + CNT_W'(1);
              end
            end
          end else begin
            idx_reg        <= idx_next;
            mem_addr       <= base_reg + {30'd0, idx_next};
            verify_bad_reg <= verify_bad_reg | rdata_bad;
          end
        end
`endif

        DONE: begin
          state_reg <= IDLE;
          in_ready  <= 1'b1;
        end

        ERR: begin
          state_reg <= IDLE;
          in_ready  <= 1'b1;
        end

        default: begin
          state_reg <= IDLE;
          in_ready  <= 1'b1;
          mem_we    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_memory_loader.sv
// Testbench for instruction_memory_loader: transaction-level model of the
// expected per-cycle outputs, checked every cycle, plus hand-computed
// literal expectations on the store contents and timing.
module tb_instruction_memory_loader;

  localparam int DEPTH = 32;
  localparam int CNT_W = 6;
`ifdef INSTMEM_LOADER_VERIFY_EN
  localparam int LAT = 9;
`else
  localparam int LAT = 5;
`endif

  logic             clk = 1'b0;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic [5:0]       op;
  logic [4:0]       rs;
  logic [4:0]       rt;
  logic [4:0]       rd;
  logic [4:0]       shamt;
  logic [5:0]       func;
  logic [31:0]      write_address;
  logic             mem_we;
  logic [31:0]      mem_addr;
  logic [7:0]       mem_wdata;
  logic [7:0]       mem_rdata;
  logic             done;
  logic             err;
  logic [CNT_W-1:0] loaded_count;

  always #5 clk = ~clk;

  instruction_memory_loader #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .func(func),
    .write_address(write_address), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .done(done), .err(err),
    .loaded_count(loaded_count)
  );

  // Byte-wide store written by the DUT; optional corruption of address 6 on read.
  logic [7:0] store [DEPTH] = '{default: 8'hEE};
  logic       corrupt = 1'b0;

  always @(posedge clk) begin
    if (mem_we && mem_addr < DEPTH) store[mem_addr[4:0]] <= mem_wdata;
  end

  assign mem_rdata = (mem_addr < DEPTH)
                   ? (store[mem_addr[4:0]] ^ ((corrupt && mem_addr == 32'd6) ? 8'h5A : 8'h00))
                   : 8'h00;

  // Expected output for one cycle.
  typedef struct {
    logic        rdy;
    logic        we;
    logic        dn;
    logic        er;
    logic        inc;
    logic        set_addr;
    logic        set_data;
    logic [31:0] addr;
    logic [7:0]  data;
  } rec_t;

  rec_t        q[$];
  int          exp_count = 0;
  logic [31:0] exp_addr = '0;
  logic [7:0]  exp_data = '0;
  logic        cur_rdy = 1'b1;
  logic [7:0]  exp_store [DEPTH] = '{default: 8'hEE};
  int          cyc = 0;
  int          accept_tick = 0;
  logic        accepted = 1'b0;
  int          done_ticks[$];
  int          err_ticks[$];
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=0x%0h required=0x%0h", name, cyc, act, req);
    end
  endtask

  function automatic rec_t mk(input logic rdy, input logic we, input logic dn, input logic er,
                              input logic inc, input logic sa, input logic sd,
                              input logic [31:0] a, input logic [7:0] d);
    rec_t r;
    r.rdy = rdy; r.we = we; r.dn = dn; r.er = er; r.inc = inc;
    r.set_addr = sa; r.set_data = sd; r.addr = a; r.data = d;
    return r;
  endfunction

  // Expand one accepted request into the cycles it must produce.
  task automatic push_request(input logic [31:0] a, input logic [31:0] w);
    logic bad;
    if (a > DEPTH - 4) begin
      q.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0));
    end else begin
      for (int k = 0; k < 4; k++) q.push_back(mk(0, 1, 0, 0, 0, 1, 1, a + k, w[31-8*k -: 8]));
      bad = 1'b0;
`ifdef INSTMEM_LOADER_VERIFY_EN
      for (int k = 0; k < 4; k++) q.push_back(mk(0, 0, 0, 0, 0, 1, 0, a + k, 0));
      bad = corrupt && (a <= 32'd6) && (32'd6 <= a + 3);
`endif
      if (bad) q.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0));
      else     q.push_back(mk(0, 0, 1, 0, 1, 0, 0, 0, 0));
    end
  endtask

  // One clock: compare at the falling edge, decide acceptance, return after the rising edge.
  task automatic tick();
    rec_t r;
    @(negedge clk);
    cyc++;
    if (!reset_n) begin
      q.delete();
      exp_count = 0; exp_addr = '0; exp_data = '0; cur_rdy = 1'b1;
      r = mk(1, 0, 0, 0, 0, 0, 0, 0, 0);
    end else if (q.size() > 0) begin
      r = q.pop_front();
      cur_rdy = r.rdy;
      if (r.set_addr) exp_addr = r.addr;
      if (r.set_data) exp_data = r.data;
      if (r.we) exp_store[r.addr[4:0]] = r.data;
      if (r.inc && exp_count < (1 << CNT_W) - 1) exp_count++;
    end else begin
      cur_rdy = 1'b1;
      r = mk(1, 0, 0, 0, 0, 0, 0, 0, 0);
    end
    chk("in_ready", in_ready, r.rdy);
    chk("mem_we", mem_we, r.we);
    chk("done", done, r.dn);
    chk("err", err, r.er);
    chk("mem_addr", mem_addr, exp_addr);
    chk("mem_wdata", mem_wdata, exp_data);
    chk("loaded_count", loaded_count, exp_count);
    if (done) done_ticks.push_back(cyc);
    if (err) err_ticks.push_back(cyc);
    accepted = 1'b0;
    if (reset_n && cur_rdy && in_valid) begin
      push_request(write_address, {op, rs, rt, rd, shamt, func});
      accepted = 1'b1;
      accept_tick = cyc;
    end
    @(posedge clk);
    #1;
  endtask

  // Present a request and hold it until taken; optionally keep in_valid high afterwards.
  task automatic send(input logic [31:0] a, input logic [5:0] o, input logic [4:0] s,
                      input logic [4:0] t, input logic [4:0] d, input logic [4:0] sh,
                      input logic [5:0] f, input logic hold);
    int n;
    write_address = a; op = o; rs = s; rt = t; rd = d; shamt = sh; func = f;
    in_valid = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!accepted && n < 40);
    if (!accepted) chk("accept_timeout", 0, 1);
    $display("txn addr=%0d word=0x%08h accepted_at=%0d", a, {o, s, t, d, sh, f}, accept_tick);
    // Fields change while busy; the word already captured must be unaffected.
    op = 6'($urandom); rs = 5'($urandom); rt = 5'($urandom);
    rd = 5'($urandom); shamt = 5'($urandom); func = 6'($urandom);
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q.size() > 0 || !cur_rdy) && n < 40) begin
      tick();
      n++;
    end
    if (q.size() > 0 || !cur_rdy) chk("idle_timeout", 0, 1);
    tick();
  endtask

  initial begin : stim
    logic [31:0] w;
    int a0;
    reset_n = 1'b0; in_valid = 1'b0; write_address = '0;
    op = '0; rs = '0; rt = '0; rd = '0; shamt = '0; func = '0;
    tick(); tick();
    chk("reset_in_ready", in_ready, 1);
    chk("reset_count", loaded_count, 0);
    reset_n = 1'b1;
    tick(); tick();

    // add $t0,$t1,$t2 at address 0
    done_ticks.delete(); err_ticks.delete();
    send(0, 6'd0, 5'd9, 5'd10, 5'd8, 5'd0, 6'h20, 1'b0);
    a0 = accept_tick;
    wait_idle();
    chk("add_done_count", done_ticks.size(), 1);
    if (done_ticks.size() > 0) chk("add_latency", done_ticks[0] - a0, LAT);
    w = {store[0], store[1], store[2], store[3]};
    chk("add_word", w, 32'h012A4020);
    chk("fetch_op", w[31:26], 0);
    chk("fetch_rs", w[25:21], 9);
    chk("fetch_rt", w[20:16], 10);
    chk("fetch_rd", w[15:11], 8);
    chk("fetch_func", w[5:0], 32'h20);
    chk("add_count", loaded_count, 1);

    // lw at the last legal base address
    done_ticks.delete(); err_ticks.delete();
    send(28, 6'h23, 5'd29, 5'd8, 5'd0, 5'd0, 6'd4, 1'b0);
    wait_idle();
    chk("lw_word", {store[28], store[29], store[30], store[31]}, 32'h8FA80004);
    chk("lw_done_count", done_ticks.size(), 1);
    chk("lw_count", loaded_count, 2);

    // one past the last legal base: rejected
    done_ticks.delete(); err_ticks.delete();
    send(29, 6'h23, 5'd1, 5'd2, 5'd3, 5'd4, 6'd5, 1'b0);
    a0 = accept_tick;
    wait_idle();
    chk("oob_no_done", done_ticks.size(), 0);
    chk("oob_err_count", err_ticks.size(), 1);
    if (err_ticks.size() > 0) chk("oob_err_latency", err_ticks[0] - a0, 1);
    chk("oob_count", loaded_count, 2);
    chk("oob_store_intact", {store[28], store[29], store[30], store[31]}, 32'h8FA80004);

    // back-to-back with in_valid held high
    reset_n = 1'b0; tick(); reset_n = 1'b1; tick();
    done_ticks.delete(); err_ticks.delete();
    send(0, 6'h08, 5'd1, 5'd2, 5'd3, 5'd4, 6'h05, 1'b1);
    send(4, 6'h0D, 5'd6, 5'd7, 5'd8, 5'd9, 6'h0A, 1'b1);
    send(8, 6'h2B, 5'd11, 5'd12, 5'd13, 5'd14, 6'h0F, 1'b0);
    wait_idle();
    chk("b2b_done_count", done_ticks.size(), 3);
    if (done_ticks.size() == 3) begin
      chk("b2b_gap1", done_ticks[1] - done_ticks[0], LAT + 1);
      chk("b2b_gap2", done_ticks[2] - done_ticks[1], LAT + 1);
    end
    chk("b2b_count", loaded_count, 3);

    // reset after two bytes of the word at address 12
    send(12, 6'd0, 5'd9, 5'd10, 5'd8, 5'd0, 6'h20, 1'b0);
    tick(); tick();
    reset_n = 1'b0;
    #1;
    chk("rst_mem_we", mem_we, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_count", loaded_count, 0);
    tick();
    reset_n = 1'b1;
    done_ticks.delete();
    tick(); tick();
    chk("rst_no_done", done_ticks.size(), 0);
    chk("rst_bytes", {store[12], store[13], store[14], store[15]}, 32'h012AEEEE);

    // read-back corruption at address 6, then a clean store
    corrupt = 1'b1;
    done_ticks.delete(); err_ticks.delete();
    send(4, 6'd0, 5'd9, 5'd10, 5'd8, 5'd0, 6'h20, 1'b0);
    a0 = accept_tick;
    wait_idle();
`ifdef INSTMEM_LOADER_VERIFY_EN
    chk("corrupt_no_done", done_ticks.size(), 0);
    chk("corrupt_err_count", err_ticks.size(), 1);
    if (err_ticks.size() > 0) chk("corrupt_err_latency", err_ticks[0] - a0, 9);
    chk("corrupt_count", loaded_count, 0);
`else
    chk("corrupt_done_count", done_ticks.size(), 1);
    chk("corrupt_count", loaded_count, 1);
`endif
    corrupt = 1'b0;
    done_ticks.delete(); err_ticks.delete();
    send(4, 6'd0, 5'd9, 5'd10, 5'd8, 5'd0, 6'h20, 1'b0);
    a0 = accept_tick;
    wait_idle();
    chk("clean_done_count", done_ticks.size(), 1);
    if (done_ticks.size() > 0) chk("clean_latency", done_ticks[0] - a0, LAT);

    // whole store against the model
    for (int i = 0; i < DEPTH; i++) chk($sformatf("store_%0d", i), store[i], exp_store[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_memory_loader.md
Name: instruction_memory_loader

Overview:
Write-side counterpart to the instruction memory fetch path. Accepts one MIPS instruction as separate R-format fields plus a byte address, packs the fields into a 32-bit word, and writes it big-endian into the byte-wide instruction store, one byte per clock. The fetch path reads back bytes addr..addr+3 as op/rs/rt/rd/shamt/func, so the bit layouts of the two must match exactly. Used by testbenches and boot logic to populate instruction memory without the `instmem.txt` file.

Parameters:
DEPTH, 32, number of bytes in the instruction store
CNT_W, 6, width of loaded_count

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous, active-low reset
in_valid  input  1  instruction fields and write_address are valid
in_ready  output  1  loader can accept an instruction this cycle
op  input  6  opcode, bits 31:26
rs  input  5  bits 25:21
rt  input  5  bits 20:16
rd  input  5  bits 15:11
shamt  input  5  bits 10:6
func  input  6  bits 5:0
write_address  input  32  byte address of the instruction's most-significant byte
mem_we  output  1  byte write strobe to the store
mem_addr  output  32  byte address for the current write
mem_wdata  output  8  byte being written
mem_rdata  input  8  combinational read of store[mem_addr]; used only with the optional feature
done  output  1  one-cycle pulse: word fully written
err  output  1  one-cycle pulse: request rejected
loaded_count  output  CNT_W  count of successfully written words, saturating

Behaviour:
- Async reset (reset_n=0), applied immediately: state=IDLE, in_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, done=0, err=0, loaded_count=0. The store contents are not reset.
- Packing: word = {op,rs,rt,rd,shamt,func}. Byte k (k=0..3) = word[31-8k -: 8] goes to write_address+k.
- States: IDLE, WRITE, DONE, ERR.
- IDLE: in_ready=1.
  - If in_valid=1 at the edge, latch the word and the base address.
  - If write_address > DEPTH-4, go to ERR.
  - Otherwise go to WRITE with byte index idx=0.
- WRITE: in_ready=0, mem_we=1, mem_addr=base+idx, mem_wdata=byte idx.
  - idx increments each clock.
  - After idx=3 is written, go to DONE.
  - Exactly 4 cycles in WRITE.
- DONE: 1 cycle with done=1, in_ready=0. loaded_count increments and saturates at 2^CNT_W-1. Then go to IDLE.
- ERR: 1 cycle with err=1, in_ready=0, mem_we=0. No store writes. loaded_count unchanged. Then go to IDLE.
- Latency: accept at edge N. mem_we is high in cycles N+1..N+4. done is high in cycle N+5. in_ready returns high in cycle N+6. Sustained throughput is 1 word per 6 cycles.
- Input fields are ignored outside IDLE. Changing them mid-write does not affect the word being written.
- Boundary: write_address = DEPTH-4 is accepted and writes the last 4 bytes. There is no wrap-around and no alignment requirement.
- Reset mid-WRITE: mem_we drops immediately. Bytes already written remain. No done pulse.
- Outputs are registered. mem_addr and mem_wdata hold their last value when mem_we=0.

Optional Feature:
Macro: INSTMEM_LOADER_VERIFY_EN

With the macro defined:
- DONE is preceded by a VERIFY state lasting 4 cycles, with mem_we=0 and mem_addr=base+idx for idx=0..3.
- mem_rdata is compared with the expected byte in each cycle.
- Any mismatch sends the FSM to ERR instead of DONE, with err=1 and no loaded_count increment.
- Latency grows by 4: done is high in cycle N+9.

Without the macro:
- No VERIFY state and mem_rdata is unused.
- Timing is exactly as given in Behaviour.

Test Plan:
- add $t0,$t1,$t2 (op=0, rs=9, rt=10, rd=8, shamt=0, func=0x20) at address 0 -> bytes 0x01,0x2A,0x40,0x20 written to addresses 0..3 on cycles N+1..N+4; done in cycle N+5; loaded_count=1. The fetch path then returns the identical fields.
- write_address=28, op=0x23 lw (rs=29, rt=8, rd/shamt/func encoding 0x0004) -> word 0x8FA80004 written to bytes 28..31, done. write_address=29 -> err pulse, no mem_we, loaded_count unchanged.
- Three back-to-back requests with in_valid held high at addresses 0, 4, 8 -> in_ready=0 during each write; three done pulses 6 cycles apart; loaded_count=3.
- reset_n=0 asserted after 2 bytes of the word at address 12 -> mem_we=0 immediately, in_ready=1, loaded_count=0; bytes 12..13 written, bytes 14..15 unchanged.
- Verify enabled with a store model that corrupts address 6 -> word at address 4 gives err in cycle N+9, no done; with an uncorrupted store, done in cycle N+9.
